// File: rtl/oam_dma.sv
// OAM DMA engine: a $4014 write halts the CPU and copies the 256-byte page {page,00..FF}
// to OAMDATA ($2004) as read/write pairs, with reads always landing on get (parity 0) cycles.
module oam_dma (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDataOut,
  input  logic        cpuWrite,
  input  logic        cpuRead,
  input  logic [7:0]  memData,
  output logic        ready,
  output logic        dmaActive,
  output logic [15:0] dmaAddr,
  output logic        dmaRead,
  output logic [7:0]  oamData,
  output logic        oamWrite,
  output logic        done
);

  // state   | meaning
  // S_IDLE  | waiting for a $4014 write, CPU runs
  // S_HALT  | CPU halted, bus still CPU-owned until it reaches a read cycle
  // S_ALIGN | one dummy DMA cycle so the first read falls on a get cycle
  // S_READ  | fetch {page,index} into the buffer
  // S_WRITE | put the buffer to $2004, advance index
  // S_DONE  | one-cycle completion pulse, CPU released
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  logic        r_parity;
  logic [7:0]  r_page;
  logic [7:0]  r_index;
  logic [7:0]  r_buffer;
  logic        r_ready;
  logic        r_dma_active;
  logic        r_dma_read;
  logic        r_oam_write;
  logic        r_done;
  logic [15:0] r_dma_addr;

  logic        w_trigger;
  logic [7:0]  w_index_inc;

  assign w_trigger   = cpuWrite && (cpuAddr == 16'h4014);
  assign w_index_inc = r_index + 8'd1;

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_parity     <= 1'b0;
      r_page       <= 8'h00;
      r_index      <= 8'h00;
      r_buffer     <= 8'h00;
      r_ready      <= 1'b1;
      r_dma_active <= 1'b0;
      r_dma_read   <= 1'b0;
      r_oam_write  <= 1'b0;
      r_done       <= 1'b0;
      r_dma_addr   <= 16'h0000;
    end else begin
      r_parity <= ~r_parity;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state <= S_HALT;
            r_page  <= cpuDataOut;
            r_index <= 8'h00;
            r_ready <= 1'b0;
          end
        end
        S_HALT: begin
          if (cpuRead) begin
            r_dma_active <= 1'b1;
            // current parity 1 means the next cycle is a get cycle
            if (r_parity) begin
              r_state    <= S_READ;
              r_dma_read <= 1'b1;
              r_dma_addr <= {r_page, r_index};
            end else begin
              r_state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          r_state    <= S_READ;
          r_dma_read <= 1'b1;
          r_dma_addr <= {r_page, r_index};
        end
        S_READ: begin
          r_state     <= S_WRITE;
          r_buffer    <= memData;
          r_dma_read  <= 1'b0;
          r_oam_write <= 1'b1;
          r_dma_addr  <= 16'h2004;
        end
        S_WRITE: begin
          r_index     <= w_index_inc;
          r_oam_write <= 1'b0;
          if (r_index == 8'hFF) begin
            r_state      <= S_DONE;
            r_dma_active <= 1'b0;
            r_dma_addr   <= 16'h0000;
            r_done       <= 1'b1;
            r_ready      <= 1'b1;
          end else begin
            r_state    <= S_READ;
            r_dma_read <= 1'b1;
            r_dma_addr <= {r_page, w_index_inc};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_dma_active <= 1'b0;
          r_dma_read   <= 1'b0;
          r_oam_write  <= 1'b0;
          r_done       <= 1'b0;
          r_dma_addr   <= 16'h0000;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign dmaActive = r_dma_active;
  assign dmaAddr   = r_dma_addr;
  assign dmaRead   = r_dma_read;
  assign oamData   = r_buffer;
  assign oamWrite  = r_oam_write;
  assign done      = r_done;

endmodule
